// File: rtl/tone_decoder_if.sv
// Tone decoder bus: square-wave input plus the decoded note/octave report.
// The master side drives the tone and observes the decode; the decoder is the slave.
interface tone_decoder_if;
  logic        tone_in;
  logic [3:0]  note;
  logic [1:0]  octave;
  logic        valid;
  logic        change;
  logic [31:0] half_period;

  modport master (
    output tone_in,
    input  note, octave, valid, change, half_period
  );

  modport slave (
    input  tone_in,
    output note, octave, valid, change, half_period
  );
endinterface

// File: rtl/tone_decoder.sv
// Tone decoder: measures the half-period of an incoming square wave and
// classifies it against the buzzer's 7-note x 3-octave table. A note is
// reported only after several consecutive half-periods match the same entry.
module tone_decoder #(
  parameter int unsigned TOL_SHIFT     = 6,
  parameter int unsigned STABLE_HALVES = 4,
  parameter logic [31:0] MIN_HALF      = 32'd1024,
  parameter logic [31:0] TIMEOUT_CYC   = 32'd1000000,
  parameter logic [31:0] BASE_1        = 32'd381680,
  parameter logic [31:0] BASE_2        = 32'd340136,
  parameter logic [31:0] BASE_3        = 32'd303030,
  parameter logic [31:0] BASE_4        = 32'd285714,
  parameter logic [31:0] BASE_5        = 32'd255102,
  parameter logic [31:0] BASE_6        = 32'd227273,
  parameter logic [31:0] BASE_7        = 32'd202429
) (
  input  logic          clk,
  input  logic          rst_n,
  tone_decoder_if.slave bus
);

  localparam int RUN_W = $clog2(STABLE_HALVES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_HALVES);

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, SEARCH, DECIDE} state_t;

  logic [2:0]       toneSync_q;
  logic             edgeDet;
  logic [31:0]      count_q;
  state_t           state_q;
  logic [2:0]       candNote_q;
  logic [1:0]       candOct_q;
  logic             matchFound_q;
  logic [2:0]       matchNote_q;
  logic [1:0]       matchOct_q;
  logic             storedValid_q;
  logic [2:0]       storedNote_q;
  logic [1:0]       storedOct_q;
  logic [RUN_W-1:0] runCount_q;
  logic [RUN_W-1:0] runCount_d;
  logic             valid_q;
  logic             change_q;
  logic [3:0]       note_q;
  logic [1:0]       octave_q;
  logic [31:0]      halfPeriod_q;
  logic [31:0]      baseVal;
  logic [31:0]      shiftedVal;
  logic [31:0]      refVal;
  logic [31:0]      refTol;
  logic [31:0]      absDiff;
  logic             candHit;
  logic             matchSame;
  logic             lockNow;

  // Two synchronizer stages plus one delay stage; either polarity of edge counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) toneSync_q <= '0;
    else        toneSync_q <= {toneSync_q[1:0], bus.tone_in};
  end

  assign edgeDet = toneSync_q[1] ^ toneSync_q[2];

  // Cycles since the last edge; parks at TIMEOUT_CYC once the line has gone quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count_q <= '0;
    else if (edgeDet)             count_q <= 32'd1;
    else if (count_q < TIMEOUT_CYC) count_q <= count_q + 32'd1;
  end

  // Reference half-period and tolerance window of the candidate examined this cycle
  always_comb begin
    baseVal    = BASE_1;
    shiftedVal = BASE_1;
    case (candNote_q)
      3'd1:    baseVal = BASE_2;
      3'd2:    baseVal = BASE_3;
      3'd3:    baseVal = BASE_4;
      3'd4:    baseVal = BASE_5;
      3'd5:    baseVal = BASE_6;
      3'd6:    baseVal = BASE_7;
      default: baseVal = BASE_1;
    endcase
    case (candOct_q)
      2'd1:    shiftedVal = baseVal >> 1;
      2'd2:    shiftedVal = baseVal << 1;
      default: shiftedVal = baseVal;
    endcase
    refVal  = shiftedVal + 32'd1;
    refTol  = refVal >> TOL_SHIFT;
    absDiff = (halfPeriod_q >= refVal) ? (halfPeriod_q - refVal) : (refVal - halfPeriod_q);
    candHit = (absDiff <= refTol);
  end

  // Next run count and lock decision, consumed only in the DECIDE cycle
  always_comb begin
    matchSame  = matchFound_q && storedValid_q &&
                 (matchNote_q == storedNote_q) && (matchOct_q == storedOct_q);
    runCount_d = '0;
    if (matchSame)         runCount_d = (runCount_q == RUN_MAX) ? RUN_MAX : runCount_q + RUN_W'(1);
    else if (matchFound_q) runCount_d = RUN_W'(1);
    lockNow    = matchFound_q && (runCount_d == RUN_MAX) && !(valid_q && matchSame);
  end

  // Measurement / search / decision sequencing with registered note report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_FIRST;
      candNote_q    <= '0;
      candOct_q     <= '0;
      matchFound_q  <= 1'b0;
      matchNote_q   <= '0;
      matchOct_q    <= '0;
      storedValid_q <= 1'b0;
      storedNote_q  <= '0;
      storedOct_q   <= '0;
      runCount_q    <= '0;
      valid_q       <= 1'b0;
      change_q      <= 1'b0;
      note_q        <= '0;
      octave_q      <= '0;
      halfPeriod_q  <= '0;
    end else begin
      change_q <= 1'b0;
      case (state_q)
        WAIT_FIRST: begin
          if (edgeDet) state_q <= MEASURE;
        end
        MEASURE: begin
          if (edgeDet) begin
            if (count_q < MIN_HALF) begin
              runCount_q <= '0;
              if (valid_q) begin
                valid_q  <= 1'b0;
                note_q   <= '0;
                octave_q <= '0;
                change_q <= 1'b1;
              end
            end else begin
              halfPeriod_q <= count_q;
              candNote_q   <= '0;
              candOct_q    <= '0;
              matchFound_q <= 1'b0;
              state_q      <= SEARCH;
            end
          end else if (count_q >= TIMEOUT_CYC) begin
            runCount_q <= '0;
            state_q    <= WAIT_FIRST;
            if (valid_q) begin
              valid_q  <= 1'b0;
              note_q   <= '0;
              octave_q <= '0;
              change_q <= 1'b1;
            end
          end
        end
        SEARCH: begin
          if (candHit && !matchFound_q) begin
            matchFound_q <= 1'b1;
            matchNote_q  <= candNote_q;
            matchOct_q   <= candOct_q;
          end
          if (candNote_q == 3'd6) begin
            candNote_q <= '0;
            if (candOct_q == 2'd2) state_q <= DECIDE;
            else                   candOct_q <= candOct_q + 2'd1;
          end else begin
            candNote_q <= candNote_q + 3'd1;
          end
        end
        DECIDE: begin
          state_q    <= MEASURE;
          runCount_q <= runCount_d;
          if (matchFound_q && !matchSame) begin
            storedValid_q <= 1'b1;
            storedNote_q  <= matchNote_q;
            storedOct_q   <= matchOct_q;
          end
          if (lockNow) begin
            valid_q  <= 1'b1;
            note_q   <= {1'b0, matchNote_q} + 4'd1;
            octave_q <= matchOct_q;
            change_q <= 1'b1;
          end else if (valid_q && !matchSame) begin
            valid_q  <= 1'b0;
            note_q   <= '0;
            octave_q <= '0;
            change_q <= 1'b1;
          end
        end
        default: state_q <= WAIT_FIRST;
      endcase
    end
  end

  assign bus.note        = note_q;
  assign bus.octave      = octave_q;
  assign bus.valid       = valid_q;
  assign bus.change      = change_q;
  assign bus.half_period = halfPeriod_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder. The note table is the buzzer table divided by 512 and
// the glitch/timeout limits are shrunk to match, so each half-period is a few
// hundred cycles. Expected outputs come from a note-level model of the decoder.
module tb_tone_decoder;

  localparam int unsigned TOL    = 6;
  localparam int unsigned STABLE = 4;
  localparam int unsigned MINH   = 64;
  localparam int unsigned TMO    = 2000;
  localparam int unsigned B1 = 745, B2 = 664, B3 = 591, B4 = 558;
  localparam int unsigned B5 = 498, B6 = 443, B7 = 395;

  logic clk = 1'b0;
  logic rst_n;

  tone_decoder_if bus ();

  tone_decoder #(
    .TOL_SHIFT(TOL), .STABLE_HALVES(STABLE), .MIN_HALF(MINH), .TIMEOUT_CYC(TMO),
    .BASE_1(B1), .BASE_2(B2), .BASE_3(B3), .BASE_4(B4),
    .BASE_5(B5), .BASE_6(B6), .BASE_7(B7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int changeSeen = 0;

  bit          mWait;
  bit          mValid;
  int          mNote;
  int          mOct;
  int          mRun;
  int          mStored;
  int          mChanges = 0;
  int unsigned mHalf;
  int unsigned gap;

  // Count change pulses a little after each rising edge
  always @(posedge clk) begin
    #2;
    if (bus.change === 1'b1) changeSeen++;
  end

  function automatic int unsigned baseOf(int n);
    case (n)
      0: return B1;
      1: return B2;
      2: return B3;
      3: return B4;
      4: return B5;
      5: return B6;
      default: return B7;
    endcase
  endfunction

  // Reference half-period of table entry c = octave*7 + (note-1)
  function automatic int unsigned refOf(int c);
    int unsigned b = baseOf(c % 7);
    int unsigned s;
    if (c / 7 == 0)      s = b;
    else if (c / 7 == 1) s = b >> 1;
    else                 s = b << 1;
    return s + 1;
  endfunction

  function automatic int classify(int unsigned meas);
    for (int c = 0; c < 21; c++) begin
      int unsigned r = refOf(c);
      int unsigned d = (meas > r) ? meas - r : r - meas;
      if (d <= (r >> TOL)) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mWait = 1'b1; mValid = 1'b0; mNote = 0; mOct = 0;
    mRun = 0; mStored = -1; mHalf = 0; gap = 0;
  endtask

  task automatic modelUnlock();
    if (mValid) begin
      mValid = 1'b0; mNote = 0; mOct = 0; mChanges++;
    end
  endtask

  task automatic modelLock(int c);
    mValid = 1'b1; mNote = c % 7 + 1; mOct = c / 7; mChanges++;
  endtask

  task automatic modelEdge(int unsigned meas);
    int c;
    if (mWait) begin
      mWait = 1'b0;
    end else if (meas < MINH) begin
      mRun = 0;
      modelUnlock();
    end else begin
      mHalf = meas;
      c = classify(meas);
      if (c < 0) begin
        mRun = 0;
        modelUnlock();
      end else if (c == mStored) begin
        if (mRun < STABLE) mRun++;
        if (mRun == STABLE && !mValid) modelLock(c);
      end else begin
        mStored = c;
        mRun = 1;
        modelUnlock();
        if (mRun == STABLE) modelLock(c);
      end
    end
  endtask

  task automatic modelTimeout();
    modelUnlock();
    mRun = 0;
    mWait = 1'b1;
  endtask

  task automatic waitCycles(int n);
    repeat (n) begin
      @(negedge clk);
      gap++;
      if (gap == TMO && !mWait) modelTimeout();
    end
  endtask

  task automatic toggleTone();
    bus.tone_in = ~bus.tone_in;
    modelEdge(gap);
    gap = 0;
  endtask

  task automatic checkOne(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkOne({tag, ".valid"},   32'(bus.valid),   32'(mValid));
    checkOne({tag, ".note"},    32'(bus.note),    32'(mNote));
    checkOne({tag, ".octave"},  32'(bus.octave),  32'(mOct));
    checkOne({tag, ".half"},    bus.half_period,  mHalf);
    checkOne({tag, ".changes"}, 32'(changeSeen),  32'(mChanges));
  endtask

  // n edges spaced h cycles apart, outputs checked once each edge has settled
  task automatic applyStimulus(int unsigned h, int n, string tag);
    for (int i = 0; i < n; i++) begin
      toggleTone();
      waitCycles(30);
      checkOutput(tag);
      waitCycles(int'(h) - 30);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.tone_in = 1'b0;
    waitCycles(2);
    modelReset();
    rst_n = 1'b1;
    waitCycles(2);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    bus.tone_in = 1'b0;
    modelReset();
    waitCycles(3);
    checkOutput("reset");
    checkOne("reset.change", 32'(bus.change), 0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] lock on note 1 octave 00 and latency");
    applyStimulus(746, 4, "t1");
    toggleTone();
    waitCycles(24);
    checkOne("t1.pre_lock_valid", 32'(bus.valid), 0);
    waitCycles(1);
    checkOne("t1.lock_valid", 32'(bus.valid), 1);
    checkOne("t1.lock_change", 32'(bus.change), 1);
    waitCycles(1);
    checkOne("t1.change_width", 32'(bus.change), 0);
    waitCycles(746 - 26);
    checkOutput("t1.locked");
    checkOne("t1.half", bus.half_period, 746);
    applyStimulus(746, 1, "t1.hold");

    $display("[TB] note change and tolerance edges");
    applyStimulus(198, 5, "t2.n7");
    checkOne("t2.note7", 32'(bus.note), 7);
    checkOne("t2.oct01", 32'(bus.octave), 1);
    applyStimulus(752, 5, "t2.n1");
    checkOne("t2.note1", 32'(bus.note), 1);
    applyStimulus(757, 2, "tol.hi");
    applyStimulus(735, 2, "tol.lo");
    applyStimulus(758, 2, "tol.out");
    checkOne("tol.out_valid", 32'(bus.valid), 0);

    $display("[TB] unmatched tone");
    doReset();
    c0 = changeSeen;
    applyStimulus(770, 6, "t3");
    checkOne("t3.no_pulses", 32'(changeSeen - c0), 0);

    $display("[TB] silence timeout");
    doReset();
    applyStimulus(997, 5, "t4.lock");
    checkOne("t4.note5", 32'(bus.note), 5);
    checkOne("t4.oct10", 32'(bus.octave), 2);
    waitCycles(int'(TMO) - 20 - 997);
    checkOutput("t4.pre_timeout");
    c0 = changeSeen;
    waitCycles(60);
    checkOutput("t4.timeout");
    checkOne("t4.silence_pulse", 32'(changeSeen - c0), 1);
    toggleTone();
    waitCycles(30);
    checkOutput("t4.restart");
    checkOne("t4.half_kept", bus.half_period, 997);
    waitCycles(970);
    applyStimulus(1000, 1, "t4.measure");
    checkOne("t4.half_new", bus.half_period, 1000);

    $display("[TB] glitch unlock and relock");
    doReset();
    applyStimulus(592, 5, "t5.lock");
    toggleTone();
    waitCycles(310);
    c0 = changeSeen;
    toggleTone();
    waitCycles(30);
    checkOutput("t5.unlock");
    checkOne("t5.unlock_pulse", 32'(changeSeen - c0), 1);
    waitCycles(10);
    toggleTone();
    waitCycles(30);
    checkOutput("t5.glitch");
    waitCycles(562);
    applyStimulus(592, 3, "t5.relearn");
    checkOne("t5.not_yet", 32'(bus.valid), 0);
    applyStimulus(592, 1, "t5.relock");
    checkOne("t5.relocked", 32'(bus.valid), 1);
    checkOne("t5.note3", 32'(bus.note), 3);

    $display("[TB] reset during search");
    doReset();
    applyStimulus(665, 5, "t6.lock");
    toggleTone();
    waitCycles(12);
    c0 = changeSeen;
    rst_n = 1'b0;
    bus.tone_in = 1'b0;
    #1;
    checkOne("t6.valid", 32'(bus.valid), 0);
    checkOne("t6.note", 32'(bus.note), 0);
    checkOne("t6.octave", 32'(bus.octave), 0);
    checkOne("t6.change", 32'(bus.change), 0);
    checkOne("t6.half", bus.half_period, 0);
    modelReset();
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(40);
    checkOne("t6.no_pulse", 32'(changeSeen - c0), 0);
    checkOutput("t6.after");
    toggleTone();
    waitCycles(30);
    checkOutput("t6.wait_first");
    waitCycles(635);
    applyStimulus(665, 1, "t6.first_meas");
    checkOne("t6.half_meas", bus.half_period, 665);

    $display("[TB] random bursts");
    doReset();
    for (int k = 0; k < 8; k++) begin
      int          cand = int'($urandom_range(0, 20));
      int unsigned r    = refOf(cand);
      int unsigned t    = r >> TOL;
      int unsigned h    = r - t - 2 + $urandom_range(0, 2 * t + 4);
      applyStimulus(h, int'($urandom_range(2, 5)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive-side counterpart of the buzzer note generator.
- Measures the half-period of an incoming square wave (`tone_in`, e.g. from another board's speaker pin or a loopback) and classifies it against the same 7-note × 3-octave half-period table the buzzer uses to generate tones.
- After a stable match, reports note (1–7) and octave code; reports note 0 on silence.
- Used for self-test loopback and for the "listen and score" game mode.

Parameters:
- TOL_SHIFT, 6, match tolerance: accept if |meas − ref| <= ref >> TOL_SHIFT (~1.6%).
- STABLE_HALVES, 4, consecutive matching half-periods on the same candidate required to lock.
- MIN_HALF, 1024, half-periods shorter than this are glitches; must be > 32.
- TIMEOUT_CYC, 1000000, cycles without an edge before declaring silence; must exceed 763361 + tolerance.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- tone_in  input  1  asynchronous square-wave input.
- note  output  4  decoded note 1..7; 0 = none/silence.
- octave  output  2  decoded octave code: 00 = base, 01 = base>>1, 10 = base<<1 (same encoding the buzzer consumes).
- valid  output  1  high while locked on a note.
- change  output  1  one-cycle pulse whenever {valid, note, octave} changes.
- half_period  output  32  last accepted measured half-period, in clk cycles.

Behaviour:
- **Reset** (async, `rst_n` = 0): note = 0, octave = 00, valid = 0, change = 0, half_period = 0, counter = 0, FSM = WAIT_FIRST, run count = 0, stored candidate = none.
- **Input conditioning:** 2-FF synchronizer on `tone_in`, plus a third register for edge detect. Both rising and falling edges count.
- **Reference table:** base B[1..7] = 381680, 340136, 303030, 285714, 255102, 227273, 202429.
  - Shifted value S = B, B>>1, or B<<1 for octave codes 00, 01, 10.
  - Reference half-period ref = S + 1, matching the buzzer's toggle every S+1 cycles.
  - 21 candidates, searched in order: octave 00, 01, 10; within each octave, notes 1..7. First match wins.
- **Counter:** increments every cycle and saturates at TIMEOUT_CYC. On a detected edge it is latched as meas, then set to 1.
- **WAIT_FIRST:** the first edge after reset or timeout only starts the counter; no measurement is taken. Go to MEASURE.
- **MEASURE:**
  - Edge with meas < MIN_HALF: glitch. Run count = 0; if valid, unlock. Stay in MEASURE.
  - Edge with meas >= MIN_HALF: half_period <= meas, go to SEARCH.
  - Counter reaches TIMEOUT_CYC: silence. If valid, unlock. Run count = 0, go to WAIT_FIRST.
- **SEARCH:** evaluates one candidate per cycle for exactly 21 cycles (fixed latency, no early exit), then DECIDE for 1 cycle, then back to MEASURE.
  - Edges cannot arrive during SEARCH/DECIDE because MIN_HALF > 32.
  - The counter keeps running during SEARCH and DECIDE.
- **DECIDE:**
  - No match: run count = 0; if valid, unlock.
  - Match c with c == stored candidate: run count + 1, saturating at STABLE_HALVES.
  - Match c with c != stored candidate: stored = c, run count = 1; if valid, unlock.
  - If run count reaches STABLE_HALVES and not valid: valid = 1, note/octave = c, pulse change.
  - While locked on c, further matches of c produce no change pulse.
- **Unlock:** valid = 0, note = 0, octave = 00, pulse change.
- **Output timing:** outputs and change are registered and update on the cycle after DECIDE. That is 23 cycles after the edge-detect cycle, plus 2 cycles of synchronizer delay.
- **Arithmetic:** all values 32-bit unsigned. The absolute difference is computed without wrap (compare first, then subtract). B<<1 fits in 32 bits.
- **Reset mid-search** aborts immediately to the reset state.

Test Plan:
1. Reset, then square wave with half-period 381681 for 6 edges. Require: valid rises with note = 1, octave = 00, and a single change pulse, 23+2 cycles after the 5th edge. half_period = 381681.
2. Half-period 101215 (202429>>1 + 1), 5 edges. Require: note = 7, octave = 01. Then half-period 385000 (within tolerance 5963 of 381681), 5 edges. Require: unlock pulse on its first measurement, then lock on note = 1, octave = 00.
3. Half-period 400000 (outside tolerance of every candidate). Require: valid stays 0, note = 0, no change pulses after reset.
4. Locked on note 5 / octave 10 (half-period 510205), then `tone_in` held constant. Require: after TIMEOUT_CYC cycles, valid = 0, note = 0, one change pulse. The next edge only restarts measurement.
5. Locked on note 3 / octave 00 (303031), then a 500-cycle glitch pulse. Require: immediate unlock with change pulse, run count reset, relock only after 4 clean half-periods.
6. Assert `rst_n` low 10 cycles into SEARCH while locked. Require: all outputs 0 asynchronously, no change pulse on release, FSM in WAIT_FIRST.
